// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by MEM/WB, ID, forwarding and write-back logic.
// Holds the WB control-bit indices, the hardwired-zero register number and
// default datapath widths.
package pipe_pkg;

  // Bit positions inside the 2-bit WB control field.
  localparam int unsigned WB_MEMTOREG = 1;
  localparam int unsigned WB_REGWRITE = 0;

  // Architectural register that always reads as zero.
  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  typedef enum logic {
    WbSelAlu = 1'b0,
    WbSelMem = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Write-back data select: load data or ALU result.
// Ports:
//   sel_i  - WbSelMem picks mem_i, WbSelAlu picks alu_i
//   alu_i  - ALU result
//   mem_i  - memory read data
//   wd_o   - selected write-back data (combinational)
module wb_mux
  import pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  wb_sel_e       sel_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] mem_i,
  output logic [DW-1:0] wd_o
);

  always_comb begin
    wd_o = (sel_i == WbSelMem) ? mem_i : alu_i;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects write-back data, commits it to the register array and serves two
// combinational read ports with same-cycle write bypass. Also tracks a count of
// committed writes and a record of the most recent one.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   WB_WB           - [1] MemtoReg, [0] RegWrite
//   ALUOut_WB       - ALU result
//   DataMEM_RD_WB   - load data
//   WN_WB           - destination register
//   RN1/RN2, RD1/RD2 - read ports
//   WD_out          - selected write-back data (to forwarding unit)
//   wb_valid        - current inputs produce an architectural write
//   wb_count        - committed writes since reset (wraps)
//   last_wn/last_wd - destination and data of the latest committed write
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      WB_WB,
  input  logic [DW-1:0]   ALUOut_WB,
  input  logic [DW-1:0]   DataMEM_RD_WB,
  input  logic [AW-1:0]   WN_WB,
  input  logic [AW-1:0]   RN1,
  input  logic [AW-1:0]   RN2,
  output logic [DW-1:0]   RD1,
  output logic [DW-1:0]   RD2,
  output logic [DW-1:0]   WD_out,
  output logic            wb_valid,
  output logic [CNTW-1:0] wb_count,
  output logic [AW-1:0]   last_wn,
  output logic [DW-1:0]   last_wd
);

  localparam int unsigned NumRegs = 2 ** AW;

  // Register 0 is not stored at all.
  logic [DW-1:0]   regs_q [1:NumRegs-1];
  logic [CNTW-1:0] wb_count_q, wb_count_d;
  logic [AW-1:0]   last_wn_q, last_wn_d;
  logic [DW-1:0]   last_wd_q, last_wd_d;
  logic [DW-1:0]   wd;

  wb_mux #(
    .DW(DW)
  ) u_wb_mux (
    .sel_i(wb_sel_e'(WB_WB[WB_MEMTOREG])),
    .alu_i(ALUOut_WB),
    .mem_i(DataMEM_RD_WB),
    .wd_o (wd)
  );

  always_comb begin
    wb_valid = WB_WB[WB_REGWRITE] & (WN_WB != AW'(REG_ZERO)) & ~reset;
    WD_out   = wd;
  end

  // Bypass only fires on a real write, so it is off during reset and for r0.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (RN1 != AW'(REG_ZERO)) begin
      RD1 = (wb_valid && (RN1 == WN_WB)) ? wd : regs_q[RN1];
    end
    if (RN2 != AW'(REG_ZERO)) begin
      RD2 = (wb_valid && (RN2 == WN_WB)) ? wd : regs_q[RN2];
    end
  end

  always_comb begin
    wb_count_d = wb_count_q;
    last_wn_d  = last_wn_q;
    last_wd_d  = last_wd_q;
    if (wb_valid) begin
      wb_count_d = wb_count_q + CNTW'(1);
      last_wn_d  = WN_WB;
      last_wd_d  = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
      last_wn_q  <= '0;
      last_wd_q  <= '0;
    end else begin
      if (wb_valid) begin
        regs_q[WN_WB] <= wd;
      end
      wb_count_q <= wb_count_d;
      last_wn_q  <= last_wn_d;
      last_wd_q  <= last_wd_d;
    end
  end

  always_comb begin
    wb_count = wb_count_q;
    last_wn  = last_wn_q;
    last_wd  = last_wd_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb;
  logic [31:0] alu, mem;
  logic [4:0]  wn, rn1, rn2;

  logic [31:0] rd1, rd2, wd_out, wb_count, last_wd;
  logic [4:0]  last_wn;
  logic        wb_valid_o;

  logic [31:0] rd1_4, rd2_4, wd_out_4, last_wd_4;
  logic [3:0]  wb_count_4;
  logic [4:0]  last_wn_4;
  logic        wb_valid_4;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state after the last clock edge.
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  logic [4:0]  m_last_wn;
  logic [31:0] m_last_wd;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .WB_WB(wb), .ALUOut_WB(alu), .DataMEM_RD_WB(mem),
    .WN_WB(wn), .RN1(rn1), .RN2(rn2), .RD1(rd1), .RD2(rd2), .WD_out(wd_out),
    .wb_valid(wb_valid_o), .wb_count(wb_count), .last_wn(last_wn), .last_wd(last_wd)
  );

  wb_regfile #(.CNTW(4)) dut4 (
    .clk(clk), .reset(reset), .WB_WB(wb), .ALUOut_WB(alu), .DataMEM_RD_WB(mem),
    .WN_WB(wn), .RN1(rn1), .RN2(rn2), .RD1(rd1_4), .RD2(rd2_4), .WD_out(wd_out_4),
    .wb_valid(wb_valid_4), .wb_count(wb_count_4), .last_wn(last_wn_4), .last_wd(last_wd_4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_wd();
    return wb[1] ? mem : alu;
  endfunction

  function automatic logic m_valid();
    return wb[0] && (wn != 5'd0) && !reset;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] rn);
    if (rn == 5'd0) return 32'd0;
    if (m_valid() && rn == wn) return m_wd();
    return m_regs[rn];
  endfunction

  // Called one time unit after a rising edge; returns just before the falling edge.
  task automatic drive(input logic r, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] m, input logic [4:0] n, input logic [4:0] r1,
                       input logic [4:0] r2);
    reset = r; wb = w; alu = a; mem = m; wn = n; rn1 = r1; rn2 = r2;
    #3;
  endtask

  task automatic check_model();
    chk("wd_out", wd_out, m_wd());
    chk("wb_valid", {31'd0, wb_valid_o}, {31'd0, m_valid()});
    chk("rd1", rd1, m_rd(rn1));
    chk("rd2", rd2, m_rd(rn2));
    chk("wb_count", wb_count, m_count);
    chk("last_wn", {27'd0, last_wn}, {27'd0, m_last_wn});
    chk("last_wd", last_wd, m_last_wd);
    chk("wb_count4", {28'd0, wb_count_4}, {28'd0, m_count[3:0]});
    chk("rd1_4", rd1_4, m_rd(rn1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count   = 32'd0;
      m_last_wn = 5'd0;
      m_last_wd = 32'd0;
    end else if (m_valid()) begin
      m_regs[wn] = m_wd();
      m_count    = m_count + 32'd1;
      m_last_wn  = wn;
      m_last_wd  = m_wd();
    end
    #1;
  endtask

  initial begin
    // Reset held two cycles; array contents are only defined after the first edge.
    drive(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    tick();
    drive(1'b1, 2'b00, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31);
    check_model();
    chk("t1_rd1", rd1, 32'd0);
    chk("t1_rd2", rd2, 32'd0);
    chk("t1_count", wb_count, 32'd0);
    tick();

    // ALU write with same-cycle bypass, then plain read.
    drive(1'b0, 2'b01, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd0);
    check_model();
    chk("t2_bypass", rd1, 32'h1234_5678);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0);
    check_model();
    chk("t2_read", rd1, 32'h1234_5678);
    chk("t2_count", wb_count, 32'd1);
    chk("t2_last_wn", {27'd0, last_wn}, 32'd8);
    tick();

    // Load write.
    drive(1'b0, 2'b11, 32'h1, 32'hDEAD_BEEF, 5'd3, 5'd1, 5'd2);
    check_model();
    chk("t3_wd", wd_out, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    check_model();
    chk("t3_read", rd2, 32'hDEAD_BEEF);
    tick();

    // Write to r0 is discarded.
    drive(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    check_model();
    chk("t4_rd1", rd1, 32'd0);
    chk("t4_valid", {31'd0, wb_valid_o}, 32'd0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    check_model();
    chk("t4_count", wb_count, 32'd2);
    tick();

    // Write in the reset cycle is dropped and not bypassed.
    drive(1'b0, 2'b01, 32'hA, 32'h0, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1'b1, 2'b01, 32'hB, 32'h0, 5'd9, 5'd9, 5'd9);
    check_model();
    chk("t5_nobypass", rd1, 32'hA);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    check_model();
    chk("t5_cleared", rd1, 32'd0);
    chk("t5_count", wb_count, 32'd0);
    tick();

    // 4-bit counter wrap: 15 writes reach all-ones, the 16th wraps to zero.
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 2'b01, 32'(i * 7 + 1), 32'h0, 5'(i + 1), 5'(i + 1), 5'd31);
      check_model();
      tick();
    end
    drive(1'b0, 2'b01, 32'h55, 32'h0, 5'd20, 5'd20, 5'd19);
    check_model();
    chk("t6_full", {28'd0, wb_count_4}, 32'd15);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    check_model();
    chk("t6_wrap", {28'd0, wb_count_4}, 32'd0);
    chk("t6_count32", wb_count, 32'd16);
    tick();

    // Randomized traffic with occasional resets and forced address collisions.
    for (int c = 0; c < 600; c++) begin
      logic [4:0] n, r1, r2;
      n  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? n : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
            n, r1, r2);
      check_model();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
